// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-4 stream demultiplexer: channel count,
// select width and channel index names.
package demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    localparam logic [SEL_W-1:0] CH0 = 2'd0;
    localparam logic [SEL_W-1:0] CH1 = 2'd1;
    localparam logic [SEL_W-1:0] CH2 = 2'd2;
    localparam logic [SEL_W-1:0] CH3 = 2'd3;

endpackage

// File: rtl/demux_ch_reg.sv
// One-entry valid/data register for a single demux output channel.
// can_load tells the producer side whether a beat can be written this cycle.
module demux_ch_reg #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [N-1:0] in_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    output logic         can_load
);

    // A full register that is draining this cycle can take a new beat.
    assign can_load = !out_valid || out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            // NOTE: the data register is reset too, so a channel never shows
            // leftover payload from before a reset.
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1x4_stream.sv
// 1-to-4 valid/ready stream demultiplexer with a one-entry register per channel.
// Define DEMUX_CNT_EN to add per-channel accepted-beat counters cnt0..cnt3.
module demux_1x4_stream
    import demux_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     in_data,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N-1:0]     out0_data,
    output logic [N-1:0]     out1_data,
    output logic [N-1:0]     out2_data,
    output logic [N-1:0]     out3_data,
    output logic             out0_valid,
    output logic             out1_valid,
    output logic             out2_valid,
    output logic             out3_valid,
    input  logic             out0_ready,
    input  logic             out1_ready,
    input  logic             out2_ready,
    input  logic             out3_ready
`ifdef DEMUX_CNT_EN
   ,output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3
`endif
);

    logic         ch_ready    [NUM_CH];
    logic         ch_valid    [NUM_CH];
    logic [N-1:0] ch_data     [NUM_CH];
    logic         ch_can_load [NUM_CH];
    logic         ch_load     [NUM_CH];
    logic         accept;

    assign ch_ready[CH0] = out0_ready;
    assign ch_ready[CH1] = out1_ready;
    assign ch_ready[CH2] = out2_ready;
    assign ch_ready[CH3] = out3_ready;

    assign out0_valid = ch_valid[CH0];
    assign out1_valid = ch_valid[CH1];
    assign out2_valid = ch_valid[CH2];
    assign out3_valid = ch_valid[CH3];
    assign out0_data  = ch_data[CH0];
    assign out1_data  = ch_data[CH1];
    assign out2_data  = ch_data[CH2];
    assign out3_data  = ch_data[CH3];

    // Readiness depends only on the addressed channel, never on in_valid.
    assign in_ready = ch_can_load[in_sel];
    assign accept   = in_valid && in_ready;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign ch_load[k] = accept && (in_sel == SEL_W'(k));

        demux_ch_reg #(.N(N)) u_ch_reg (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (ch_load[k]),
            .in_data   (in_data),
            .out_ready (ch_ready[k]),
            .out_valid (ch_valid[k]),
            .out_data  (ch_data[k]),
            .can_load  (ch_can_load[k])
        );
    end

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt_q [NUM_CH];

    // Counters wrap naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (ch_load[k]) cnt_q[k] <= cnt_q[k] + 1'b1;
            end
        end
    end

    assign cnt0 = cnt_q[CH0];
    assign cnt1 = cnt_q[CH1];
    assign cnt2 = cnt_q[CH2];
    assign cnt3 = cnt_q[CH3];
`endif

endmodule

// File: tb/tb_demux_1x4_stream.sv
// Directed-vector bench for demux_1x4_stream; counter checks are active
// only when DEMUX_CNT_EN is defined.
module tb_demux_1x4_stream;

    localparam int N     = 4;
    localparam int CNT_W = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] in_data;
    logic [1:0]   in_sel;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] od   [4];
    logic         ov   [4];
    logic         ordy [4];
`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt [4];
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    demux_1x4_stream #(.N(N), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (od[0]),
        .out1_data  (od[1]),
        .out2_data  (od[2]),
        .out3_data  (od[3]),
        .out0_valid (ov[0]),
        .out1_valid (ov[1]),
        .out2_valid (ov[2]),
        .out3_valid (ov[3]),
        .out0_ready (ordy[0]),
        .out1_ready (ordy[1]),
        .out2_ready (ordy[2]),
        .out3_ready (ordy[3])
`ifdef DEMUX_CNT_EN
       ,.cnt0       (cnt[0]),
        .cnt1       (cnt[1]),
        .cnt2       (cnt[2]),
        .cnt3       (cnt[3])
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [N-1:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        #1;
    endtask

    task automatic expect_ch(input string tag, input int k, input logic v, input logic [N-1:0] d);
        check($sformatf("%s valid%0d", tag, k), 32'(ov[k]), 32'(v));
        if (v) check($sformatf("%s data%0d", tag, k), 32'(od[k]), 32'(d));
    endtask

    task automatic expect_reset_state(input string tag);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s valid%0d", tag, k), 32'(ov[k]), 32'd0);
            check($sformatf("%s data%0d", tag, k), 32'(od[k]), 32'd0);
        end
    endtask

    initial begin
        int cexp [5];
        cexp = '{1, 2, 3, 0, 1};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sel   = 2'd0;
        in_data  = '0;
        for (int k = 0; k < 4; k++) ordy[k] = 1'b0;
        #1;
        expect_reset_state("reset");
        check("reset in_ready", 32'(in_ready), 32'd1);

        // Release reset mid-cycle; first accept on the very next edge.
        #11;
        rst_n = 1'b1;
        drive(1'b1, 2'd2, 4'hA);
        check("first in_ready", 32'(in_ready), 32'd1);
        tick();
        expect_ch("first", 2, 1'b1, 4'hA);
        expect_ch("first", 0, 1'b0, 4'h0);
        expect_ch("first", 1, 1'b0, 4'h0);
        expect_ch("first", 3, 1'b0, 4'h0);

        // Backpressure on channel 2.
        drive(1'b1, 2'd2, 4'h5);
        for (int c = 0; c < 5; c++) begin
            check("bp in_ready", 32'(in_ready), 32'd0);
            tick();
            expect_ch("bp hold", 2, 1'b1, 4'hA);
        end
        drive(1'b1, 2'd1, 4'h3);
        check("bp other in_ready", 32'(in_ready), 32'd1);
        tick();
        expect_ch("bp other", 1, 1'b1, 4'h3);
        expect_ch("bp other", 2, 1'b1, 4'hA);

        // Drain channels 1 and 2.
        drive(1'b0, 2'd2, 4'hF);
        ordy[1] = 1'b1;
        ordy[2] = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) expect_ch("drain", k, 1'b0, 4'h0);
        ordy[1] = 1'b0;
        ordy[2] = 1'b0;

        // Simultaneous drain and fill on channel 0.
        drive(1'b1, 2'd0, 4'h1);
        tick();
        expect_ch("fill0", 0, 1'b1, 4'h1);
        ordy[0] = 1'b1;
        drive(1'b1, 2'd0, 4'h2);
        check("reload in_ready", 32'(in_ready), 32'd1);
        tick();
        expect_ch("reload", 0, 1'b1, 4'h2);
        drive(1'b0, 2'd0, 4'h0);
        tick();
        expect_ch("reload drain", 0, 1'b0, 4'h0);

        // Round-robin stream with every consumer ready.
        for (int k = 0; k < 4; k++) ordy[k] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'(i % 4), 4'(i));
            check($sformatf("rr in_ready %0d", i), 32'(in_ready), 32'd1);
            tick();
            expect_ch($sformatf("rr %0d", i), i % 4, 1'b1, 4'(i));
            if (i > 0) expect_ch($sformatf("rr prev %0d", i), (i - 1) % 4, 1'b0, 4'h0);
        end
        drive(1'b0, 2'd0, 4'h0);
        tick();
        for (int k = 0; k < 4; k++) expect_ch("rr end", k, 1'b0, 4'h0);
        for (int k = 0; k < 4; k++) ordy[k] = 1'b0;

        // Asynchronous reset with channels 1 and 3 full.
        drive(1'b1, 2'd1, 4'h7);
        tick();
        drive(1'b1, 2'd3, 4'h9);
        tick();
        drive(1'b0, 2'd0, 4'h0);
        expect_ch("pre-reset", 1, 1'b1, 4'h7);
        expect_ch("pre-reset", 3, 1'b1, 4'h9);
        #1;
        rst_n = 1'b0;
        #1;
        expect_reset_state("async reset");
        check("async reset in_ready", 32'(in_ready), 32'd1);
        tick();
        expect_reset_state("held reset");
        #2;
        rst_n = 1'b1;

        // Five accepts to channel 3 (counters wrap at CNT_W=2).
        ordy[3] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'd3, 4'(i + 1));
            check($sformatf("cnt run in_ready %0d", i), 32'(in_ready), 32'd1);
            tick();
            expect_ch($sformatf("cnt run %0d", i), 3, 1'b1, 4'(i + 1));
`ifdef DEMUX_CNT_EN
            check($sformatf("cnt3 %0d", i), 32'(cnt[3]), 32'(cexp[i]));
            for (int k = 0; k < 3; k++)
                check($sformatf("cnt%0d idle %0d", k, i), 32'(cnt[k]), 32'd0);
`else
            if (cexp[i] < 0) check("cnt table", 32'(cexp[i]), 32'd0);
`endif
        end
        drive(1'b0, 2'd0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/demux_1x4_stream.md
Name: demux_1x4_stream

Overview:
- 1-to-4 demultiplexer; the inverse of the team's parameterised 4:1 mux.
- Routes an N-bit input beat to one of four output channels, chosen by a 2-bit sel that travels with the data.
- Valid/ready handshakes on the input and on every output.
- Each output channel has a one-entry register, so a stalled channel does not block beats bound for other channels.
- Sits between a single producer and four independent consumers.

Parameters:
- N, 4, data width in bits of the input and of each output.
- CNT_W, 8, width of the per-channel beat counters (used only with DEMUX_CNT_EN).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N  input beat.
- in_sel  input  2  destination channel (0..3); sampled only when in_valid=1.
- in_valid  input  1  producer has a beat.
- in_ready  output  1  demux accepts the beat this cycle.
- out0_data, out1_data, out2_data, out3_data  output  N each  channel data, registered.
- out0_valid .. out3_valid  output  1 each  channel register holds a beat.
- out0_ready .. out3_ready  input  1 each  consumer takes the beat.
- cnt0 .. cnt3  output  CNT_W each  accepted-beat counters (present only with DEMUX_CNT_EN).

Interface rule: one clock; reset is asynchronous and active-low; ports named clk and rst_n.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all outK_valid=0, all outK_data=0, all cntK=0.
  - in_ready reflects the empty state, so it is 1.
  - Beats pending in channel registers are discarded; no partial state survives.
  - After deassertion, the first accept can occur on the first rising edge.
- Per channel K, register state:
  - EMPTY (valid=0) or FULL (valid=1).
  - EMPTY -> FULL on accept with sel=K.
  - FULL -> EMPTY on outK_ready=1 with no accept to K that cycle.
  - FULL -> FULL on simultaneous drain and accept to K: the register is reloaded with the new data and valid stays 1.
- in_ready = !outS_valid || outS_ready, where S = in_sel.
  - Combinational, and independent of in_valid.
- Accept = in_valid && in_ready. On accept, in_data is written into channel in_sel at the rising edge.
- Latency: 1 cycle. A beat accepted at edge T is visible on outK at T+1. There is no combinational path from in_data to outK_data.
- While outK_valid=1 and outK_ready=0:
  - outK_data is held stable.
  - A beat for K is refused (in_ready=0).
  - Beats for other, non-full channels are still accepted.
- Channels drain independently; any subset may drain in the same cycle.
- in_sel is a don't-care when in_valid=0, and no state changes.
- Each beat is written to exactly one channel. No broadcast, no drop, no reordering within a channel.
- outK_ready while outK_valid=0 has no effect.

Optional Feature:
- Macro: DEMUX_CNT_EN.
- Defined:
  - Ports cnt0..cnt3 exist.
  - cntK increments by 1 on every accept routed to K.
  - Wraps modulo 2^CNT_W, from 2^CNT_W-1 to 0.
  - Reset to 0.
  - Counter update does not affect handshake timing.
- Undefined:
  - Ports and counter logic are absent.
  - Datapath and handshake behaviour are identical.

Decomposition:
- Package demux_pkg holds:
  - NUM_CH=4, SEL_W=2;
  - channel index constants CH0..CH3.
- Sub-module demux_ch_reg (parameter N) is the one-entry valid/data register with load, drain and ready logic. Instantiated 4x.
- The top level holds the sel decode, in_ready mux and optional counters.

Test Plan:
- Reset release, all outK_ready=0:
  - in_valid=1, in_sel=2, in_data=4'hA -> in_ready=1 at cycle 0.
  - Next cycle: out2_valid=1, out2_data=4'hA; other valids 0.
- Backpressure, channel 2 full with 4'hA, out2_ready=0:
  - Drive sel=2, data=4'h5 -> in_ready=0; out2_data holds 4'hA for 5 cycles.
  - Then drive sel=1, data=4'h3 -> accepted; out1_data=4'h3 the next cycle.
- Simultaneous drain and fill, channel 0 full with 4'h1:
  - out0_ready=1, in sel=0, data=4'h2 -> in_ready=1.
  - Next cycle: out0_valid=1, out0_data=4'h2.
- Round-robin stream:
  - Sel 0,1,2,3,0,… with data 0..7 and all readys=1.
  - Each channel receives its beats in order, 1-cycle latency; in_ready never drops.
- Reset mid-operation:
  - Channels 1 and 3 full; pulse rst_n=0 between clock edges.
  - All valids drop to 0 immediately (asynchronously); data reads 0.
- With DEMUX_CNT_EN, CNT_W=2:
  - 5 accepts to channel 3 -> cnt3 sequence 1,2,3,0,1; other counters 0.
  - Without the macro: same stimulus gives identical out/in_ready waveforms.
